// File: rtl/ram_arbiter_if.sv
// Bundle of all handshake, response and RAM-side signals of the two-port
// RAM arbiter. The slave modport is the arbiter's view and the master
// modport is the view of whatever drives the requesters and models the RAM.
interface ram_arbiter_if #(
    parameter int AW    = 10,
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic             req0_we;
    logic [AW-1:0]    req0_addr;
    logic [WIDTH-1:0] req0_wdata;
    logic             req1_valid;
    logic             req1_ready;
    logic             req1_we;
    logic [AW-1:0]    req1_addr;
    logic [WIDTH-1:0] req1_wdata;
    logic             rsp0_valid;
    logic [WIDTH-1:0] rsp0_data;
    logic             rsp1_valid;
    logic [WIDTH-1:0] rsp1_data;
    logic             ram_we;
    logic [AW-1:0]    ram_addr;
    logic [WIDTH-1:0] ram_wdata;
    logic [WIDTH-1:0] ram_rdata;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        output ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        input  ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port, read-latency-1 RAM between
// two requesters. Grants are combinational from the valids and a 1-bit
// last-grant register; read responses come back exactly one cycle later.
module ram_arbiter #(
    parameter  int DEPTH = 1024,
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    ram_arbiter_if.slave  bus
);
    // Per-port views gathered into vectors so the grant logic is symmetric
    logic [1:0]       valid;
    logic [1:0]       we;
    logic [AW-1:0]    addr [2];
    logic [WIDTH-1:0] wdata [2];

    logic [1:0]       grant;
    // 1 = port 1 was granted last, so port 0 wins the next conflict
    logic             last_grant_reg;
    logic [1:0]       rsp_valid_reg;

    assign valid    = {bus.req1_valid, bus.req0_valid};
    assign we       = {bus.req1_we, bus.req0_we};
    assign addr[0]  = bus.req0_addr;
    assign addr[1]  = bus.req1_addr;
    assign wdata[0] = bus.req0_wdata;
    assign wdata[1] = bus.req1_wdata;

    // Work-conserving round-robin grant; nothing is granted during reset
    always_comb begin
        grant = 2'b00;
        if (!rst) begin
            grant[0] = valid[0] && (!valid[1] || last_grant_reg);
            grant[1] = valid[1] && (!valid[0] || !last_grant_reg);
        end
    end

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];

    // Steer the winner onto the RAM port; drive zeros when idle
    always_comb begin
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        if (grant[0]) begin
            bus.ram_we    = we[0];
            bus.ram_addr  = addr[0];
            bus.ram_wdata = wdata[0];
        end else if (grant[1]) begin
            bus.ram_we    = we[1];
            bus.ram_addr  = addr[1];
            bus.ram_wdata = wdata[1];
        end
    end

    // Track the last granted port and flag granted reads for one cycle;
    // reset discards any read still in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_reg <= 1'b1;
            rsp_valid_reg  <= 2'b00;
        end else begin
            if (|grant) begin
                last_grant_reg <= grant[1];
            end
            rsp_valid_reg <= grant & ~we;
        end
    end

    assign bus.rsp0_valid = rsp_valid_reg[0];
    assign bus.rsp1_valid = rsp_valid_reg[1];
    // Read data is only exposed while its response is valid
    assign bus.rsp0_data  = rsp_valid_reg[0] ? bus.ram_rdata : '0;
    assign bus.rsp1_data  = rsp_valid_reg[1] ? bus.ram_rdata : '0;
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, giving the RAM word count.
REQ-002 The block SHALL have parameter WIDTH, default 32, giving the data width in bits.
REQ-003 The block SHALL use AW = clog2(DEPTH) as the address width (10 for the default DEPTH).
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have ports reqN_valid, input, 1 bit, for N = 0 and 1: requester N presents an access.
REQ-007 The block SHALL have ports reqN_ready, output, 1 bit: the access of requester N is issued this cycle.
REQ-008 The block SHALL have ports reqN_we, input, 1 bit: 1 = write, 0 = read.
REQ-009 The block SHALL have ports reqN_addr, input, AW bits: word address.
REQ-010 The block SHALL have ports reqN_wdata, input, WIDTH bits: write data.
REQ-011 The block SHALL have ports rspN_valid, output, 1 bit: read data for requester N is valid this cycle.
REQ-012 The block SHALL have ports rspN_data, output, WIDTH bits: read data for requester N.
REQ-013 The block SHALL have port ram_we, output, 1 bit: RAM write enable.
REQ-014 The block SHALL have port ram_addr, output, AW bits: RAM address.
REQ-015 The block SHALL have port ram_wdata, output, WIDTH bits: RAM write data.
REQ-016 The block SHALL have port ram_rdata, input, WIDTH bits: RAM registered read data, valid one cycle after the address.

Function
REQ-017 The block SHALL share one single-port, synchronous, read-latency-1 RAM between two requesters and issue at most one access per cycle.
REQ-018 An access SHALL issue in any cycle where reqN_valid and reqN_ready are both 1.
REQ-019 reqN_ready SHALL be combinational from the valids and the priority register, with no other dependency.
REQ-020 Requesters SHALL hold valid, we, addr and wdata stable until ready is returned.
REQ-021 If exactly one valid is high, that requester SHALL be granted the same cycle (work-conserving).
REQ-022 If both valids are high, the requester not granted most recently SHALL win (round-robin); the loser's ready SHALL be 0.
REQ-023 A 1-bit priority register SHALL record the last granted port, update only on a grant, and hold when idle.
REQ-024 In the grant cycle, ram_we, ram_addr and ram_wdata SHALL equal the winner's we, addr and wdata, combinationally.
REQ-025 With no grant, ram_we SHALL be 0, ram_addr 0 and ram_wdata 0.
REQ-026 A granted read SHALL assert rspN_valid for exactly one cycle, on the cycle after the grant (latency 1).
REQ-027 rspN_valid SHALL be a registered output.
REQ-028 rspN_data SHALL equal ram_rdata while rspN_valid is 1, and SHALL be 0 otherwise.
REQ-029 A granted write SHALL produce no response.
REQ-030 Back-to-back reads SHALL each produce a response in consecutive cycles, with no bubbles.
REQ-031 rsp0_valid and rsp1_valid SHALL never both be 1.
REQ-032 Requesters SHALL accept responses unconditionally; responses have no backpressure.
REQ-033 A read of an address written in the same cycle is impossible (one port only).
REQ-034 A read issued in the cycle after a write to the same address SHALL return the new data.

Reset
REQ-035 While rst is 1: rsp0_valid and rsp1_valid SHALL be 0, and the priority register SHALL be set so port 0 wins the first conflict.
REQ-036 While rst is 1: req0_ready, req1_ready and ram_we SHALL be forced to 0.
REQ-037 Reset asserted mid-operation SHALL drop a pending read response; no rspN_valid SHALL assert for an access issued before reset.

Verification
REQ-038 Reset release, req0_valid=1 and req1_valid=1, both reads, held for 4 cycles -> grants 0,1,0,1; responses on rsp0,rsp1,rsp0,rsp1 one cycle later each.
REQ-039 req1 write addr=0x005 data=0xDEADBEEF, then req0 read addr=0x005 -> rsp0_valid 1 cycle after read grant, rsp0_data=0xDEADBEEF; rsp1_valid stays 0.
REQ-040 Only req1_valid=1, reads, for 3 cycles -> req1_ready=1 every cycle; 3 consecutive rsp1_valid pulses.
REQ-041 Idle cycle between grants (last grant port 1), then both valid -> port 0 wins; ram_we=0, ram_addr=0 during the idle cycle.
REQ-042 rst asserted the cycle after a read grant to addr=0x3FF -> rsp0_valid stays 0; after release, first conflict goes to port 0.
REQ-043 Random 10k-cycle mixed traffic against a reference memory model -> every read matches the model; the valid/ready hold rule is never violated; no lost or duplicated response.
